// File: rtl/adxl362_readings_display_scheduler.sv
// ADXL362 readings display scheduler.
// Periodically freezes the latest accelerometer reading for the readings-to-ASCII converter,
// registers the converter's lines and hands them to the PMOD CLS writer, then the UART.
// Build option: define ADXL362_SCHED_UART_EN to include the UART stage; without it the
// sequence ends after the CLS stage and o_uart_tx_go stays low.
module adxl362_readings_display_scheduler #(
  parameter int unsigned PARAM_REFRESH_CYCLES      = 2000000,
  parameter int unsigned PARAM_INACTIVE_CYCLES     = 10000000,
  parameter int unsigned PARAM_DONE_TIMEOUT_CYCLES = 4000000
) (
  input  logic         i_clk_20mhz,
  input  logic         i_rst_20mhz,
  input  logic [63:0]  i_3axis_temp,
  input  logic         i_reading_valid,
  input  logic         i_mode_txt,
  output logic [63:0]  o_3axis_temp,
  output logic         o_reading_inactive,
  input  logic [127:0] i_dat_line1,
  input  logic [127:0] i_dat_line2,
  input  logic [127:0] i_txt_line1,
  input  logic [127:0] i_txt_line2,
  output logic [127:0] o_line1,
  output logic [127:0] o_line2,
  output logic         o_cls_wr_go,
  input  logic         i_cls_wr_done,
  output logic         o_uart_tx_go,
  input  logic         i_uart_tx_done,
  output logic [7:0]   o_timeout_count,
  output logic         o_busy
);

  localparam int unsigned RefW   = (PARAM_REFRESH_CYCLES > 1) ? $clog2(PARAM_REFRESH_CYCLES) : 1;
  localparam int unsigned StaleW = (PARAM_INACTIVE_CYCLES > 0) ?
                                   $clog2(PARAM_INACTIVE_CYCLES + 1) : 1;
  localparam int unsigned WaitW  = (PARAM_DONE_TIMEOUT_CYCLES > 1) ?
                                   $clog2(PARAM_DONE_TIMEOUT_CYCLES) : 1;

  localparam logic [RefW-1:0]   RefLast  = RefW'(PARAM_REFRESH_CYCLES - 1);
  localparam logic [StaleW-1:0] StaleMax = StaleW'(PARAM_INACTIVE_CYCLES);
  // The wait counter starts at 0 on the first WAIT cycle, so a value of TIMEOUT-1 marks the
  // last cycle of the budget and the exit lands exactly TIMEOUT cycles after entry.
  localparam logic [WaitW-1:0]  WaitLast = WaitW'(PARAM_DONE_TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle, StLatch, StLoad, StClsGo, StClsWait, StUartGo, StUartWait
  } state_e;

`ifdef ADXL362_SCHED_UART_EN
  localparam state_e AfterCls = StUartGo;
`else
  localparam state_e AfterCls = StIdle;
`endif

  state_e            state_q, state_d;
  logic [RefW-1:0]   ref_cnt_q;
  logic [StaleW-1:0] stale_cnt_q;
  logic [WaitW-1:0]  wait_cnt_q;
  logic [63:0]       capture_q;
  logic              mode_q;
  logic              pending_q;
  logic              tick;
  logic              stale;
  logic              wait_expired;
  logic              timeout_hit;

  assign tick         = (ref_cnt_q == RefLast);
  assign stale        = (stale_cnt_q == StaleMax);
  assign wait_expired = (wait_cnt_q == WaitLast);

  assign o_busy      = (state_q != StIdle);
  // Gated by reset so an abort landing on a GO cycle never leaks a request.
  assign o_cls_wr_go = (state_q == StClsGo) && !i_rst_20mhz;
`ifdef ADXL362_SCHED_UART_EN
  assign o_uart_tx_go = (state_q == StUartGo) && !i_rst_20mhz;
`else
  logic unused_uart_tx_done;
  assign unused_uart_tx_done = i_uart_tx_done;
  assign o_uart_tx_go        = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; done pulses only count in their own WAIT state.
  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    unique case (state_q)
      StIdle:  if (tick || pending_q) state_d = StLatch;
      StLatch: state_d = StLoad;
      StLoad:  state_d = StClsGo;
      StClsGo: state_d = StClsWait;
      StClsWait: begin
        if (i_cls_wr_done || wait_expired) state_d = AfterCls;
        timeout_hit = !i_cls_wr_done && wait_expired;
      end
`ifdef ADXL362_SCHED_UART_EN
      StUartGo: state_d = StUartWait;
      StUartWait: begin
        if (i_uart_tx_done || wait_expired) state_d = StIdle;
        timeout_hit = !i_uart_tx_done && wait_expired;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Refresh timebase, reading capture/staleness and the single-deep pending refresh.
  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      ref_cnt_q   <= '0;
      stale_cnt_q <= StaleMax;
      capture_q   <= '0;
      pending_q   <= 1'b0;
    end else begin
      ref_cnt_q <= tick ? '0 : ref_cnt_q + 1'b1;
      if (i_reading_valid) begin
        capture_q   <= i_3axis_temp;
        stale_cnt_q <= '0;
      end else if (!stale) begin
        stale_cnt_q <= stale_cnt_q + 1'b1;
      end
      // IDLE always consumes a pending refresh; extra ticks while pending are dropped.
      if (state_q == StIdle) begin
        pending_q <= 1'b0;
      end else if (tick) begin
        pending_q <= 1'b1;
      end
    end
  end

  // Snapshot for the converter, then the converter's lines one cycle later.
  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      o_3axis_temp       <= '0;
      o_reading_inactive <= 1'b1;
      mode_q             <= 1'b0;
      o_line1            <= '0;
      o_line2            <= '0;
    end else begin
      if (state_q == StLatch) begin
        o_3axis_temp       <= capture_q;
        o_reading_inactive <= stale;
        mode_q             <= i_mode_txt;
      end
      if (state_q == StLoad) begin
        o_line1 <= mode_q ? i_txt_line1 : i_dat_line1;
        o_line2 <= mode_q ? i_txt_line2 : i_dat_line2;
      end
    end
  end

  // Consumer wait counter (cleared in each GO cycle) and saturating timeout tally.
  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      wait_cnt_q      <= '0;
      o_timeout_count <= '0;
    end else begin
      if (state_q == StClsGo || state_q == StUartGo) begin
        wait_cnt_q <= '0;
      end else if (!wait_expired) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end
      if (timeout_hit && o_timeout_count != 8'hFF) begin
        o_timeout_count <= o_timeout_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_adxl362_readings_display_scheduler.sv
// Bench for adxl362_readings_display_scheduler: scripted consumers, a converter model and a
// scoreboard of expected CLS requests (cycle, snapshot, stale flag, lines).
`timescale 1ns/1ps
module tb_adxl362_readings_display_scheduler;

`ifdef ADXL362_SCHED_UART_EN
  localparam bit UartEn = 1'b1;
`else
  localparam bit UartEn = 1'b0;
`endif

  typedef struct {
    int          go_cyc;
    logic [63:0] snap;
    logic        inact;
    logic        txt;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [63:0]  temp_in = '0;
  logic         valid = 1'b0;
  logic         mode_txt = 1'b0;
  logic [63:0]  snap;
  logic         inact;
  logic [127:0] dat1, dat2, txt1, txt2, line1, line2;
  logic         cls_go, uart_go, busy;
  logic         cls_done = 1'b0;
  logic         uart_done = 1'b0;
  logic [7:0]   to_cnt;
  logic         d2_cls_go, d2_uart_go, d2_busy;
  logic         d2_cls_done = 1'b0;
  logic         d2_uart_done = 1'b0;
  logic [7:0]   d2_to_cnt;
  logic [63:0]  unused_d2_snap;
  logic         unused_d2_inact;
  logic [127:0] unused_d2_line1, unused_d2_line2;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   cls_go_at = -1000;
  int   uart_go_at = -1000;
  exp_t sb[$];

  localparam logic [63:0] ValA = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] ValB = 64'h0F1E_2D3C_4B5A_6978;

  // Converter model: each line carries the snapshot in a distinct, mode-specific layout.
  function automatic logic [127:0] conv(input logic [63:0] s, input logic i, input logic txt,
                                        input bit second);
    if (txt) return second ? {64'h7777_2222_7777_2222, ~s} : {s, 63'h0, i};
    else     return second ? {~s, 64'hDADA_2222_DADA_2222} : {64'hDADA_1111_DADA_1111, s};
  endfunction

  assign dat1 = conv(snap, inact, 1'b0, 1'b0);
  assign dat2 = conv(snap, inact, 1'b0, 1'b1);
  assign txt1 = conv(snap, inact, 1'b1, 1'b0);
  assign txt2 = conv(snap, inact, 1'b1, 1'b1);

  adxl362_readings_display_scheduler #(
    .PARAM_REFRESH_CYCLES      (100),
    .PARAM_INACTIVE_CYCLES     (250),
    .PARAM_DONE_TIMEOUT_CYCLES (20)
  ) dut (
    .i_clk_20mhz (clk), .i_rst_20mhz (rst), .i_3axis_temp (temp_in),
    .i_reading_valid (valid), .i_mode_txt (mode_txt), .o_3axis_temp (snap),
    .o_reading_inactive (inact), .i_dat_line1 (dat1), .i_dat_line2 (dat2),
    .i_txt_line1 (txt1), .i_txt_line2 (txt2), .o_line1 (line1), .o_line2 (line2),
    .o_cls_wr_go (cls_go), .i_cls_wr_done (cls_done), .o_uart_tx_go (uart_go),
    .i_uart_tx_done (uart_done), .o_timeout_count (to_cnt), .o_busy (busy)
  );

  // Long consumer timeout so a transfer can span several refresh ticks.
  adxl362_readings_display_scheduler #(
    .PARAM_REFRESH_CYCLES      (100),
    .PARAM_INACTIVE_CYCLES     (250),
    .PARAM_DONE_TIMEOUT_CYCLES (400)
  ) dut2 (
    .i_clk_20mhz (clk), .i_rst_20mhz (rst), .i_3axis_temp (temp_in),
    .i_reading_valid (valid), .i_mode_txt (mode_txt), .o_3axis_temp (unused_d2_snap),
    .o_reading_inactive (unused_d2_inact), .i_dat_line1 (dat1), .i_dat_line2 (dat2),
    .i_txt_line1 (txt1), .i_txt_line2 (txt2), .o_line1 (unused_d2_line1),
    .o_line2 (unused_d2_line2), .o_cls_wr_go (d2_cls_go), .i_cls_wr_done (d2_cls_done),
    .o_uart_tx_go (d2_uart_go), .i_uart_tx_done (d2_uart_done),
    .o_timeout_count (d2_to_cnt), .o_busy (d2_busy)
  );

  always #25 clk = ~clk;

  // Cycle 0 is the first cycle after the last reset edge.
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; cls_done = 1'b0; uart_done = 1'b0;
    d2_cls_done = 1'b0; d2_uart_done = 1'b0;
    step();
    step();
    rst = 1'b0;
    cls_go_at = -1000;
    uart_go_at = -1000;
    sb.delete();
  endtask

  // Consumer model: done pulses a fixed number of cycles after each go (0 = never).
  task automatic respond(input int cls_dly, input int uart_dly);
    if (cls_go) cls_go_at = cyc;
    if (uart_go) uart_go_at = cyc;
    cls_done  = (cls_dly > 0) && (cyc == cls_go_at + cls_dly);
    uart_done = (uart_dly > 0) && (cyc == uart_go_at + uart_dly);
  endtask

  task automatic test_reset();
    int gos = 0;
    do_reset();
    checks++;
    if ({snap, inact} !== {64'h0, 1'b1}) begin
      failures++;
      $display("FAIL reset_snapshot: got %h/%b, required 0/1", snap, inact);
    end
    checks++;
    if ({line1, line2} !== 256'h0) begin
      failures++;
      $display("FAIL reset_lines: got %h %h, required 0 0", line1, line2);
    end
    checks++;
    if ({cls_go, uart_go, to_cnt, busy, d2_busy} !== 12'h0) begin
      failures++;
      $display("FAIL reset_ctrl: got go=%b/%b to=%0d busy=%b/%b, required all 0",
               cls_go, uart_go, to_cnt, busy, d2_busy);
    end
    while (cyc < 100) begin
      step();
      if (cls_go) gos++;
      if (cyc == 99) begin
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL reset_idle_until_tick: got busy=%b at 99, required 0", busy);
        end
      end
    end
    checks++;
    if ({busy, gos} !== {1'b1, 32'd0}) begin
      failures++;
      $display("FAIL first_tick: got busy=%b gos=%0d at 100, required busy=1 gos=0", busy, gos);
    end
  endtask

  task automatic test_first_refresh();
    exp_t e;
    do_reset();
    mode_txt = 1'b0;
    sb.push_back('{102, 64'h0, 1'b1, 1'b0});
    while (cyc < 130) begin
      step();
      respond(5, 7);
      if (cls_go) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL first_extra_go: got go at %0d, required none", cyc);
        end else begin
          e = sb.pop_front();
          if ({cyc, snap, inact, line1} !== {e.go_cyc, e.snap, e.inact, conv(e.snap, e.inact,
              e.txt, 1'b0)}) begin
            failures++;
            $display("FAIL first_go: got cyc=%0d snap=%h inact=%b l1=%h, required cyc=%0d %h %b",
                     cyc, snap, inact, line1, e.go_cyc, e.snap, e.inact);
          end
        end
      end
    end
    checks++;
    if (uart_go_at !== (UartEn ? 108 : -1000)) begin
      failures++;
      $display("FAIL first_uart_go: got cycle %0d, required %0d", uart_go_at,
               UartEn ? 108 : -1000);
    end
    checks++;
    if ({sb.size(), to_cnt, busy} !== {32'd0, 8'd0, 1'b0}) begin
      failures++;
      $display("FAIL first_end: got pending=%0d to=%0d busy=%b, required 0 0 0",
               sb.size(), to_cnt, busy);
    end
  endtask

  task automatic test_capture();
    exp_t e;
    bit   stable = 1'b1;
    do_reset();
    mode_txt = 1'b0;
    sb.push_back('{102, ValA, 1'b0, 1'b0});
    sb.push_back('{202, ValB, 1'b0, 1'b0});
    while (cyc < 230) begin
      step();
      temp_in = (cyc < 50) ? ValA : ValB;
      valid   = (cyc == 10) || (cyc == 100);
      respond(5, 7);
      if (cls_go) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL capture_extra_go: got go at %0d, required none", cyc);
        end else begin
          e = sb.pop_front();
          if ({cyc, snap, inact, line1, line2} !== {e.go_cyc, e.snap, e.inact,
              conv(e.snap, e.inact, e.txt, 1'b0), conv(e.snap, e.inact, e.txt, 1'b1)}) begin
            failures++;
            $display("FAIL capture_go: got cyc=%0d snap=%h inact=%b, required cyc=%0d %h %b",
                     cyc, snap, inact, e.go_cyc, e.snap, e.inact);
          end
        end
      end
      if (cyc >= 102 && cyc < 200 && busy)
        stable &= (line1 === conv(ValA, 1'b0, 1'b0, 1'b0)) &&
                  (line2 === conv(ValA, 1'b0, 1'b0, 1'b1)) && (snap === ValA) && !inact;
    end
    valid = 1'b0;
    checks++;
    if ({stable, sb.size()} !== {1'b1, 32'd0}) begin
      failures++;
      $display("FAIL capture_hold: got stable=%b left=%0d, required 1 0", stable, sb.size());
    end
  endtask

  task automatic test_cls_timeout();
    int idle_at = -1;
    do_reset();
    while (cyc < 140) begin
      step();
      respond(0, 3);
      if (cyc == 102) cls_done = 1'b1;  // coincident with GO: must be ignored
      if (cyc > 102 && !busy && idle_at < 0) idle_at = cyc;
    end
    cls_done = 1'b0;
    checks++;
    if (uart_go_at !== (UartEn ? 123 : -1000)) begin
      failures++;
      $display("FAIL timeout_uart_go: got cycle %0d, required %0d", uart_go_at,
               UartEn ? 123 : -1000);
    end
    checks++;
    if (idle_at !== (UartEn ? 127 : 123)) begin
      failures++;
      $display("FAIL timeout_idle: got cycle %0d, required %0d", idle_at, UartEn ? 127 : 123);
    end
    checks++;
    if (to_cnt !== 8'd1) begin
      failures++;
      $display("FAIL timeout_count: got %0d, required 1", to_cnt);
    end
  endtask

  task automatic test_pending();
    exp_t e;
    int   pend_go = UartEn ? 360 : 356;
    do_reset();
    sb.push_back('{102, 64'h0, 1'b1, 1'b0});
    sb.push_back('{pend_go, 64'h0, 1'b1, 1'b0});
    sb.push_back('{402, 64'h0, 1'b1, 1'b0});
    while (cyc < 402) begin
      step();
      d2_cls_done  = (cyc == 352) || (cyc == pend_go + 2);
      d2_uart_done = UartEn && ((cyc == 356) || (cyc == pend_go + 5));
      if (d2_cls_go) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL pending_extra_go: got go at %0d, required none", cyc);
        end else begin
          e = sb.pop_front();
          if (cyc !== e.go_cyc) begin
            failures++;
            $display("FAIL pending_go: got go at %0d, required %0d", cyc, e.go_cyc);
          end
        end
      end
    end
    d2_cls_done = 1'b0;
    d2_uart_done = 1'b0;
    checks++;
    if ({sb.size(), d2_to_cnt} !== {32'd0, 8'd0}) begin
      failures++;
      $display("FAIL pending_end: got left=%0d to=%0d, required 0 0", sb.size(), d2_to_cnt);
    end
  endtask

  task automatic test_stale();
    exp_t e;
    do_reset();
    mode_txt = 1'b1;
    sb.push_back('{102, ValA, 1'b0, 1'b1});
    sb.push_back('{202, ValA, 1'b0, 1'b1});
    sb.push_back('{302, ValA, 1'b1, 1'b1});
    sb.push_back('{402, ValB, 1'b0, 1'b1});
    while (cyc < 405) begin
      step();
      temp_in = (cyc < 200) ? ValA : ValB;
      valid   = (cyc == 5) || (cyc == 350);
      respond(2, 3);
      if (cls_go) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL stale_extra_go: got go at %0d, required none", cyc);
        end else begin
          e = sb.pop_front();
          if ({cyc, snap, inact, line1, line2} !== {e.go_cyc, e.snap, e.inact,
              conv(e.snap, e.inact, e.txt, 1'b0), conv(e.snap, e.inact, e.txt, 1'b1)}) begin
            failures++;
            $display("FAIL stale_go: got cyc=%0d snap=%h inact=%b l1=%h, required cyc=%0d %h %b",
                     cyc, snap, inact, line1, e.go_cyc, e.snap, e.inact);
          end
        end
      end
    end
    valid = 1'b0;
    mode_txt = 1'b0;
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL stale_missing: got %0d requests outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    int gos = 0;
    do_reset();
    temp_in = ValA;
    while (cyc < 105) begin
      step();
      valid = (cyc == 10);
      respond(0, 0);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({snap, inact, line1, line2, cls_go, uart_go, to_cnt, busy} !==
        {64'h0, 1'b1, 256'h0, 1'b0, 1'b0, 8'h0, 1'b0}) begin
      failures++;
      $display("FAIL abort_outputs: got snap=%h inact=%b l1=%h go=%b busy=%b, required reset",
               snap, inact, line1, cls_go, busy);
    end
    rst = 1'b0;
    cls_done = 1'b1;  // late completion from the aborted transfer
    while (cyc < 102) begin
      step();
      cls_done = 1'b0;
      if (cyc < 102 && (cls_go || uart_go)) gos++;
      if (cyc == 50) begin
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL abort_late_done: got busy=%b at 50, required 0", busy);
        end
      end
    end
    checks++;
    if ({gos, cls_go} !== {32'd0, 1'b1}) begin
      failures++;
      $display("FAIL abort_next_go: got early=%0d go@102=%b, required 0 1", gos, cls_go);
    end
  endtask

  initial begin
    test_reset();
    test_first_refresh();
    test_capture();
    test_cls_timeout();
    test_pending();
    test_stale();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got no completion by 5 ms, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
